spi_ram_master: RTL
===================

SPI_RAM_MASTER -- requirements
Module: spi_ram_master

Interface
REQ-001 Parameter TURNAROUND, default 2, meaning idle cycles between last MOSI bit and first MISO sample of a read-data frame (legal range 1..15).
REQ-002 Parameter GAP, default 1, meaning minimum SS_n-high cycles between frames (legal range 1..15).
REQ-003 clk  input  1  system clock; also the SPI bit clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  host command request.
REQ-006 cmd_ready  output  1  master can accept a command.
REQ-007 cmd_op  input  2  opcode: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
REQ-008 cmd_data  input  8  address or write data; don't-care payload for rd-data.
REQ-009 resp_valid  output  1  one-cycle pulse, read data valid.
REQ-010 resp_data  output  8  read data byte.
REQ-011 SS_n  output  1  slave select, active-low.
REQ-012 MOSI  output  1  serial data to slave.
REQ-013 MISO  input  1  serial data from slave.

Function
REQ-014 States SHALL be IDLE, SEL, CMD, SHIFT, TURN, RECV, GAP.
REQ-015 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1, latching frame={cmd_op,cmd_data} (10 bits).
REQ-016 IDLE->SEL on accept; SEL lasts 1 cycle with SS_n=0, MOSI=0.
REQ-017 CMD lasts 1 cycle with SS_n=0, MOSI=cmd_op[1].
REQ-018 SHIFT lasts 10 cycles; MOSI=frame[9] down to frame[0], MSB first, one bit per cycle, SS_n=0.
REQ-019 After SHIFT: op 00/01/10 -> GAP; op 11 -> TURN.
REQ-020 TURN lasts TURNAROUND cycles, SS_n=0, MOSI=0.
REQ-021 RECV lasts 8 cycles, SS_n=0; MISO sampled on each rising edge into bit positions 0 through 7, LSB first.
REQ-022 At the edge ending RECV, resp_data SHALL load the assembled byte and resp_valid SHALL be 1 for exactly the following cycle; resp_data holds until the next read-data frame completes.
REQ-023 GAP lasts GAP cycles with SS_n=1, MOSI=0, then -> IDLE.
REQ-024 SS_n low duration: 12 cycles for ops 00/01/10; 20+TURNAROUND cycles for op 11.
REQ-025 Accept-to-resp_valid latency for op 11: 21+TURNAROUND cycles (cycle after accept = 1).
REQ-026 cmd_valid/cmd_op/cmd_data changes after accept SHALL NOT affect the frame in progress.
REQ-027 Bit and wait counters SHALL be 4 bits, count down, no wrap past 0.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 On rst=1, asynchronously: state=IDLE, SS_n=1, MOSI=0, cmd_ready=0 while rst asserted, resp_valid=0, resp_data=0x00, counters=0.
REQ-030 Reset mid-frame SHALL raise SS_n immediately; no resp_valid for the aborted frame; cmd_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-031 Macro SPI_RAM_MASTER_ABORT_EN: when defined, adds input abort (1 bit); abort=1 in SEL/CMD/SHIFT/TURN/RECV SHALL force GAP on the next edge (SS_n=1 next cycle), suppress resp_valid, ignore abort in IDLE/GAP; when undefined, no abort port exists and frames always complete.

Verification
REQ-032 Reset: assert rst mid-SHIFT -> SS_n=1 same cycle, resp_valid=0, cmd_ready=1 cycle after release.
REQ-033 Write addr: op=00, data=0xA5 -> SS_n low 12 cycles, MOSI sequence 0,0,0,0,1,0,1,0,0,1,0,1, no resp_valid.
REQ-034 Read data: op=11, TURNAROUND=2, slave drives MISO LSB-first 0x3C -> resp_valid at accept+23, resp_data=0x3C, SS_n low 22 cycles.
REQ-035 Back-to-back: cmd_valid held with ops 01 then 10 -> exactly GAP SS_n-high cycles between frames, cmd_ready low throughout each frame.
REQ-036 Abort (SPI_RAM_MASTER_ABORT_EN defined): abort in 3rd RECV cycle of op 11 -> SS_n=1 next cycle, no resp_valid, resp_data unchanged.

Source files
------------

// File: rtl/spi_ram_master.sv
// SPI RAM master: serialises a 10-bit {op, payload} frame MSB first and, for
// read-data ops, waits a turnaround and captures one byte LSB first from MISO.
// The SPI bit clock is the system clock, and every output comes from a flop.
// Optional feature macro: SPI_RAM_MASTER_ABORT_EN adds an abort input that cuts
// the active frame short and goes straight to the inter-frame gap.
module spi_ram_master #(
    parameter int unsigned TURNAROUND = 2,
    parameter int unsigned GAP        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       resp_valid,
    output logic [7:0] resp_data,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
`ifdef SPI_RAM_MASTER_ABORT_EN
   ,input  logic       abort
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StCmd,
        StShift,
        StTurn,
        StRecv,
        StGap
    } state_e;

    // Down-counter reload values; the counter reaches 0 in a state's last cycle.
    localparam logic [3:0] TurnLd  = 4'(TURNAROUND - 1);
    localparam logic [3:0] GapLd   = 4'(GAP - 1);
    localparam logic [3:0] ShiftLd = 4'd9;
    localparam logic [3:0] RecvLd  = 4'd7;

    state_e     r_state, w_state_d;
    logic [3:0] r_cnt, w_cnt_d;
    logic [9:0] r_frame, w_frame_d;
    logic [1:0] r_op, w_op_d;
    logic [7:0] r_rx, w_rx_d;
    logic [7:0] r_rdata, w_rdata_d;
    logic       r_rv, w_rv_d;
    logic       r_mosi, w_mosi_d;
    logic       r_ss_n, w_ss_n_d;
    logic       r_cmd_ready, w_cmd_ready_d;
    logic       w_abort;
    logic       w_in_frame;

`ifdef SPI_RAM_MASTER_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_frame_d = r_frame;
        w_op_d    = r_op;
        w_rx_d    = r_rx;
        w_rdata_d = r_rdata;
        w_rv_d    = 1'b0;
        w_mosi_d  = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_state_d = StSel;
                    w_frame_d = {cmd_op, cmd_data};
                    w_op_d    = cmd_op;
                end
            end
            StSel: begin
                w_state_d = StCmd;
                w_mosi_d  = r_frame[9];
            end
            StCmd: begin
                // The frame register shifts left so bit 9 is always the next bit out.
                w_state_d = StShift;
                w_cnt_d   = ShiftLd;
                w_mosi_d  = r_frame[9];
                w_frame_d = {r_frame[8:0], 1'b0};
            end
            StShift: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_d   = r_cnt - 4'd1;
                    w_mosi_d  = r_frame[9];
                    w_frame_d = {r_frame[8:0], 1'b0};
                end else if (r_op == 2'b11) begin
                    w_state_d = StTurn;
                    w_cnt_d   = TurnLd;
                end else begin
                    w_state_d = StGap;
                    w_cnt_d   = GapLd;
                end
            end
            StTurn: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_d = r_cnt - 4'd1;
                end else begin
                    w_state_d = StRecv;
                    w_cnt_d   = RecvLd;
                end
            end
            StRecv: begin
                // LSB first: the first sampled bit ends up in position 0.
                w_rx_d = {MISO, r_rx[7:1]};
                if (r_cnt != 4'd0) begin
                    w_cnt_d = r_cnt - 4'd1;
                end else begin
                    w_state_d = StGap;
                    w_cnt_d   = GapLd;
                    w_rdata_d = {MISO, r_rx[7:1]};
                    w_rv_d    = 1'b1;
                end
            end
            StGap: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_d = r_cnt - 4'd1;
                end else begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = 4'd0;
            end
        endcase

        w_in_frame = (r_state == StSel) || (r_state == StCmd) || (r_state == StShift) ||
                     (r_state == StTurn) || (r_state == StRecv);

        // Abort wins over normal sequencing and drops any pending response.
        if (w_abort && w_in_frame) begin
            w_state_d = StGap;
            w_cnt_d   = GapLd;
            w_mosi_d  = 1'b0;
            w_rv_d    = 1'b0;
            w_rdata_d = r_rdata;
        end

        w_ss_n_d      = !((w_state_d == StSel) || (w_state_d == StCmd) ||
                          (w_state_d == StShift) || (w_state_d == StTurn) ||
                          (w_state_d == StRecv));
        w_cmd_ready_d = (w_state_d == StIdle);
    end

    // State and output registers; reset forces SS_n high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= 4'd0;
            r_frame     <= 10'd0;
            r_op        <= 2'd0;
            r_rx        <= 8'd0;
            r_rdata     <= 8'd0;
            r_rv        <= 1'b0;
            r_mosi      <= 1'b0;
            r_ss_n      <= 1'b1;
            r_cmd_ready <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_frame     <= w_frame_d;
            r_op        <= w_op_d;
            r_rx        <= w_rx_d;
            r_rdata     <= w_rdata_d;
            r_rv        <= w_rv_d;
            r_mosi      <= w_mosi_d;
            r_ss_n      <= w_ss_n_d;
            r_cmd_ready <= w_cmd_ready_d;
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign resp_valid = r_rv;
    assign resp_data  = r_rdata;
    assign SS_n       = r_ss_n;
    assign MOSI       = r_mosi;

endmodule
